// File: rtl/ssd_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_display_driver
//  Description : Sequential binary-to-BCD conversion (double dabble, one bit
//                per cycle) driving a 4-digit multiplexed seven-segment display.
//                Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
//  Revision    : 1.0  initial release
// ============================================================================
module ssd_display_driver #(
    parameter int WIDTH        = 13,
    parameter int REFRESH_BITS = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] num,
    output logic [3:0]       anode,
    output logic [6:0]       seg,
    output logic [15:0]      bcd,
    output logic             busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
    localparam logic [3:0] c_LAST_BIT = 4'(WIDTH - 1);

    logic [1:0]              r_state;
    logic [WIDTH-1:0]        r_shift;
    logic [WIDTH-1:0]        r_last_num;
    logic [15:0]             r_scratch;
    logic [3:0]              r_bit_cnt;
    logic                    r_start_pending;
    logic [15:0]             r_bcd;
    logic                    r_busy;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [3:0]              r_anode;
    logic [6:0]              r_seg;

    logic [15:0] w_adjusted;
    logic [1:0]  w_sel;
    logic [3:0]  w_nibble;
    logic        w_blank;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_adjusted = dabble_adjust(r_scratch);

    // Conversion FSM; bcd only changes in DONE so the display never sees partial results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_shift         <= '0;
            r_last_num      <= '0;
            r_scratch       <= '0;
            r_bit_cnt       <= '0;
            r_start_pending <= 1'b1;
            r_bcd           <= '0;
            r_busy          <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_start_pending || (num != r_last_num)) begin
                        r_shift         <= num;
                        r_last_num      <= num;
                        r_scratch       <= '0;
                        r_bit_cnt       <= '0;
                        r_start_pending <= 1'b0;
                        r_busy          <= 1'b1;
                        r_state         <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    {r_scratch, r_shift} <= {w_adjusted, r_shift} << 1;
                    r_bit_cnt            <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_bcd   <= r_scratch;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign w_sel    = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_nibble = r_bcd[w_sel*4 +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // w_lead_zero[k]: nibbles k..3 are all zero; the units digit is never blanked
    logic [3:0] w_lead_zero;
    assign w_lead_zero[0] = 1'b0;
    for (genvar k = 1; k < 4; k++) begin : g_lead_zero
        assign w_lead_zero[k] = (r_bcd[15:4*k] == '0);
    end
    assign w_blank = w_lead_zero[w_sel];
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_anode   <= 4'b1111;
            r_seg     <= 7'b1111111;
        end else begin
            r_refresh <= r_refresh + 1'b1;
            r_anode   <= ~(4'b0001 << w_sel);
            r_seg     <= w_blank ? 7'b1111111 : seg_decode(w_nibble);
        end
    end

    assign anode = r_anode;
    assign seg   = r_seg;
    assign bcd   = r_bcd;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ssd_display_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ssd_display_driver
//  Description : Self-checking bench for ssd_display_driver against a decimal
//                arithmetic model of conversion latency and digit scanning.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ssd_display_driver;

    localparam int WIDTH        = 13;
    localparam int REFRESH_BITS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] num = '0;
    logic [3:0]       anode;
    logic [6:0]       seg;
    logic [15:0]      bcd;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;
    int shown = 0;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};
    int pow10 [4] = '{1, 10, 100, 1000};

    ssd_display_driver #(
        .WIDTH       (WIDTH),
        .REFRESH_BITS(REFRESH_BITS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .num  (num),
        .anode(anode),
        .seg  (seg),
        .bcd  (bcd),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; the scan position follows from this count alone
    always @(posedge clk) edges <= rst ? 0 : edges + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_scan();
        int d;
        logic [6:0] exp_seg;
        repeat (16) begin
            tick();
            d       = ((edges - 1) / 4) % 4;
            exp_seg = seg_tab[(shown / pow10[d]) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && shown < pow10[d]) exp_seg = 7'b1111111;
`endif
            check_value("scan_anode", 32'(anode), 32'(4'hF & ~(4'b0001 << d)));
            check_value("scan_seg", 32'(seg), 32'(exp_seg));
        end
    endtask

    task automatic convert(input int v, input bit scan);
        int busy_cnt;
        logic [15:0] old_bcd;
        busy_cnt = 0;
        old_bcd  = to_bcd(shown);
        num      = WIDTH'(v);
        repeat (14) begin
            tick();
            if (busy) busy_cnt++;
        end
        check_value("hold_during_conv", 32'(bcd), 32'(old_bcd));
        check_value("busy_cycles", busy_cnt, 14);
        tick();
        check_value("bcd_result", 32'(bcd), 32'(to_bcd(v)));
        check_value("busy_after", 32'(busy), 0);
        shown = v;
        if (scan) check_scan();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        rst = 1'b1;
        num = '0;
        repeat (3) tick();
        check_value("rst_anode", 32'(anode), 32'h0000000F);
        check_value("rst_seg", 32'(seg), 32'h0000007F);
        check_value("rst_bcd", 32'(bcd), 0);
        check_value("rst_busy", 32'(busy), 0);

        rst = 1'b0;
        tick();
        check_value("first_anode", 32'(anode), 32'h0000000E);
        repeat (13) tick();
        check_value("post_rst_busy", 32'(busy), 1);
        tick();
        check_value("post_rst_bcd", 32'(bcd), 0);
        check_value("post_rst_idle", 32'(busy), 0);
        shown = 0;
        check_scan();

        convert(1234, 1'b1);
        convert(8191, 1'b0);
        convert(0, 1'b0);
        convert(9, 1'b1);
        convert(42, 1'b1);

        // Input changes mid-conversion: old value completes, then a restart
        num = WIDTH'(100);
        repeat (5) tick();
        num = WIDTH'(555);
        repeat (10) tick();
        check_value("midchg_first", 32'(bcd), 32'h00000100);
        repeat (14) tick();
        check_value("midchg_hold", 32'(bcd), 32'h00000100);
        tick();
        check_value("midchg_final", 32'(bcd), 32'h00000555);
        shown = 555;

        // Reset in the middle of a conversion
        num = WIDTH'(777);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check_value("midrst_bcd", 32'(bcd), 0);
        check_value("midrst_busy", 32'(busy), 0);
        check_value("midrst_anode", 32'(anode), 32'h0000000F);
        rst   = 1'b0;
        shown = 0;
        repeat (14) tick();
        check_value("midrst_hold", 32'(bcd), 0);
        tick();
        check_value("midrst_final", 32'(bcd), 32'h00000777);
        shown = 777;
        check_scan();

        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 8191));
            while (v == shown) v = int'($urandom_range(0, 8191));
            convert(v, (i % 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
